// File: rtl/kamus_pkg.sv
// kamus_pkg
//   Shared definitions for the Kamus-V machine-mode CSR file.
//   - operation_e : CSR instruction encodings carried on csr_op_i.
//   - csr_e       : CSR addresses decoded by kamus_csr_unit.
//   - mstatus/mie bit positions, mcause codes and the MISA value.
//   - csr_ro_range: flags addresses in the read-only CSR ranges.
//   MTIME/MTIMEH and MTIMECMP/MTIMECMPH sit in the custom machine
//   read/write space (0x7C0-0x7C3). Kamus-V exposes the timer as CSRs
//   rather than as memory-mapped registers.
package kamus_pkg;

  typedef enum logic [5:0] {
    CSRRW = 6'h01,
    CSRRS = 6'h02,
    CSRRC = 6'h03
  } operation_e;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MIP       = 12'h344,
    CSR_MTIME     = 12'h7C0,
    CSR_MTIMEH    = 12'h7C1,
    CSR_MTIMECMP  = 12'h7C2,
    CSR_MTIMECMPH = 12'h7C3,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_TIME      = 12'hC01,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_TIMEH     = 12'hC81,
    CSR_INSTRETH  = 12'hC82,
    CSR_MVENDORID = 12'hF11,
    CSR_MARCHID   = 12'hF12,
    CSR_MIMPID    = 12'hF13,
    CSR_MHARTID   = 12'hF14
  } csr_e;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MTIP_BIT     = 7;

  localparam logic [31:0] MCAUSE_INSTR_MISALIGNED = 32'd0;
  localparam logic [31:0] MCAUSE_ILLEGAL_INSTR    = 32'd2;
  localparam logic [31:0] MCAUSE_BREAKPOINT       = 32'd3;
  localparam logic [31:0] MCAUSE_LOAD_MISALIGNED  = 32'd4;
  localparam logic [31:0] MCAUSE_STORE_MISALIGNED = 32'd6;
  localparam logic [31:0] MCAUSE_ECALL_M          = 32'd11;
  localparam logic [31:0] MCAUSE_M_TIMER_IRQ      = 32'h8000_0007;

  localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

  // User counter aliases and the machine information registers.
  function automatic logic csr_ro_range(input logic [11:0] addr);
    return ((addr >= 12'hC00) && (addr <= 12'hC82)) ||
           ((addr >= 12'hF10) && (addr <= 12'hF14));
  endfunction

endpackage

// File: rtl/kamus_csr_counter.sv
// kamus_csr_counter
//   W-bit free-running counter with an increment enable and separate
//   writes for the low 32-bit word and the upper W-32 bits.
//   A word write takes priority over the increment in the same cycle,
//   and the untouched half keeps its value.
// Ports
//   clk    in  1   clock
//   rst    in  1   asynchronous active-high reset (clears the count)
//   inc    in  1   add one this cycle
//   wr_lo  in  1   load wdata into bits [31:0]
//   wr_hi  in  1   load wdata[W-33:0] into bits [W-1:32]
//   wdata  in  32  write data
//   value  out W   current count
module kamus_csr_counter #(
  parameter int unsigned W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          wr_lo,
  input  logic          wr_hi,
  input  logic [31:0]   wdata,
  output logic [W-1:0]  value
);

  localparam int unsigned HI_W = W - 32;

  // Software writes win over counting so the written value is exactly
  // what a following read observes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[W-1:32] <= wdata[HI_W-1:0];
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/kamus_csr_unit.sv
// kamus_csr_unit
//   Machine-mode CSR file for the Kamus-V RV32I core, beside the EX stage.
//   Executes CSRRW/CSRRS/CSRRC with a registered one-cycle result, owns
//   mcycle/minstret/mtime, mtimecmp and the timer interrupt, and applies
//   trap entry and MRET updates to mstatus/mepc/mcause.
// Configuration macro
//   KAMUS_CSR_TIMER_EN : defined -> MTIMECMP[H] registers, MTIP, timer_irq_o.
//                        undefined -> MTIMECMP[H] illegal, mip reads 0,
//                        timer_irq_o tied 0 (mtime still counts).
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   csr_req_i/op_i/addr_i/wdata_i CSR instruction request
//   csr_valid_o/rdata_o/illegal_o registered result, one cycle after request
//   instr_ret_i                   instruction retired (minstret increment)
//   trap_i/trap_pc_i/trap_cause_i trap entry
//   mret_i                        MRET retiring
//   mtvec_o, mepc_o               trap vector and return PC
//   timer_irq_o                   registered MTIP & MTIE & mstatus.MIE
module kamus_csr_unit
  import kamus_pkg::*;
#(
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned TIME_DIV  = 1,
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_req_i,
  input  logic [5:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_valid_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instr_ret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        timer_irq_o
);

  logic             mstatus_mie;
  logic             mstatus_mpie;
  logic             mie_mtie;
  logic [31:0]      mtvec;
  logic [31:0]      mepc;
  logic [31:0]      mcause;
  logic [31:0]      mscratch;
  logic [31:0]      prescale;
  logic             time_tick;
  logic [CNT_W-1:0] mcycle;
  logic [CNT_W-1:0] minstret;
  logic [CNT_W-1:0] mtime;
  logic [31:0]      mstatus_val;
  logic [31:0]      mip_val;
  logic [31:0]      read_val;
  logic             addr_known;
  logic             op_ok;
  logic             wr_effect;
  logic             illegal;
  logic             do_write;
  logic [31:0]      new_val;
  logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause;
  logic we_mcycle, we_mcycleh, we_minstret, we_minstreth, we_mtime, we_mtimeh;
  logic we_mtimecmp, we_mtimecmph;

`ifdef KAMUS_CSR_TIMER_EN
  logic [CNT_W-1:0] mtimecmp;
  logic             mtip;
`endif

  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;

  // MPP is hard-wired to M-mode; only MIE and MPIE are real state.
  always_comb begin
    mstatus_val                   = 32'h0000_1800;
    mstatus_val[MSTATUS_MIE_BIT]  = mstatus_mie;
    mstatus_val[MSTATUS_MPIE_BIT] = mstatus_mpie;
  end

`ifdef KAMUS_CSR_TIMER_EN
  assign mtip = (mtime >= mtimecmp);
  always_comb begin
    mip_val               = '0;
    mip_val[MIP_MTIP_BIT] = mtip;
  end
`else
  assign mip_val = '0;
`endif

  // Read mux; also tells whether the address exists at all.
  always_comb begin
    read_val   = '0;
    addr_known = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS:                read_val = mstatus_val;
      CSR_MISA:                   read_val = MISA_RV32I;
      CSR_MIE:                    read_val[MIE_MTIE_BIT] = mie_mtie;
      CSR_MTVEC:                  read_val = mtvec;
      CSR_MSCRATCH:               read_val = mscratch;
      CSR_MEPC:                   read_val = mepc;
      CSR_MCAUSE:                 read_val = mcause;
      CSR_MIP:                    read_val = mip_val;
      CSR_MCYCLE, CSR_CYCLE:      read_val = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:    read_val = 32'(mcycle >> 32);
      CSR_MINSTRET, CSR_INSTRET:  read_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: read_val = 32'(minstret >> 32);
      CSR_MTIME, CSR_TIME:        read_val = mtime[31:0];
      CSR_MTIMEH, CSR_TIMEH:      read_val = 32'(mtime >> 32);
`ifdef KAMUS_CSR_TIMER_EN
      CSR_MTIMECMP:               read_val = mtimecmp[31:0];
      CSR_MTIMECMPH:              read_val = 32'(mtimecmp >> 32);
`endif
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: read_val = '0;
      CSR_MHARTID:                read_val = HART_ID;
      default:                    addr_known = 1'b0;
    endcase
  end

  // RS/RC with a zero operand are pure reads, so they may target
  // read-only CSRs without faulting.
  always_comb begin
    op_ok     = (csr_op_i == CSRRW) || (csr_op_i == CSRRS) || (csr_op_i == CSRRC);
    wr_effect = (csr_op_i == CSRRW) || (csr_wdata_i != 32'h0);
    illegal   = !op_ok || !addr_known || (wr_effect && csr_ro_range(csr_addr_i));
    do_write  = csr_req_i && !illegal && wr_effect;
    case (csr_op_i)
      CSRRS:   new_val = read_val | csr_wdata_i;
      CSRRC:   new_val = read_val & ~csr_wdata_i;
      default: new_val = csr_wdata_i;
    endcase
  end

  // One write strobe per writable register. Writes to MISA and MIP are
  // accepted but have no effect.
  always_comb begin
    we_mstatus   = 1'b0;
    we_mie       = 1'b0;
    we_mtvec     = 1'b0;
    we_mscratch  = 1'b0;
    we_mepc      = 1'b0;
    we_mcause    = 1'b0;
    we_mcycle    = 1'b0;
    we_mcycleh   = 1'b0;
    we_minstret  = 1'b0;
    we_minstreth = 1'b0;
    we_mtime     = 1'b0;
    we_mtimeh    = 1'b0;
    we_mtimecmp  = 1'b0;
    we_mtimecmph = 1'b0;
    if (do_write) begin
      case (csr_addr_i)
        CSR_MSTATUS:   we_mstatus   = 1'b1;
        CSR_MIE:       we_mie       = 1'b1;
        CSR_MTVEC:     we_mtvec     = 1'b1;
        CSR_MSCRATCH:  we_mscratch  = 1'b1;
        CSR_MEPC:      we_mepc      = 1'b1;
        CSR_MCAUSE:    we_mcause    = 1'b1;
        CSR_MCYCLE:    we_mcycle    = 1'b1;
        CSR_MCYCLEH:   we_mcycleh   = 1'b1;
        CSR_MINSTRET:  we_minstret  = 1'b1;
        CSR_MINSTRETH: we_minstreth = 1'b1;
        CSR_MTIME:     we_mtime     = 1'b1;
        CSR_MTIMEH:    we_mtimeh    = 1'b1;
        CSR_MTIMECMP:  we_mtimecmp  = 1'b1;
        CSR_MTIMECMPH: we_mtimecmph = 1'b1;
        default: ;
      endcase
    end
  end

  // Registered access result; rdata is zero whenever the access faulted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csr_valid_o   <= 1'b0;
      csr_rdata_o   <= '0;
      csr_illegal_o <= 1'b0;
    end else begin
      csr_valid_o   <= csr_req_i;
      csr_rdata_o   <= (csr_req_i && !illegal) ? read_val : 32'h0;
      csr_illegal_o <= csr_req_i && illegal;
    end
  end

  // Trap entry outranks MRET, and both outrank a software write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc         <= '0;
      mcause       <= '0;
    end else begin
      if (trap_i) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (we_mstatus) begin
        mstatus_mie  <= new_val[MSTATUS_MIE_BIT];
        mstatus_mpie <= new_val[MSTATUS_MPIE_BIT];
      end
      if (trap_i) begin
        mepc   <= trap_pc_i;
        mcause <= trap_cause_i;
      end else begin
        if (we_mepc)   mepc   <= {new_val[31:2], 2'b00};
        if (we_mcause) mcause <= new_val;
      end
    end
  end

  // Plain software-owned registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_mtie <= 1'b0;
      mscratch <= '0;
      mtvec    <= {MTVEC_RST[31:2], 2'b00};
    end else begin
      if (we_mie)      mie_mtie <= new_val[MIE_MTIE_BIT];
      if (we_mscratch) mscratch <= new_val;
      if (we_mtvec)    mtvec    <= {new_val[31:2], 2'b00};
    end
  end

  // mtime prescaler: one tick every TIME_DIV cycles, independent of
  // any software write to mtime.
  assign time_tick = (prescale == 32'(TIME_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prescale <= '0;
    else       prescale <= time_tick ? 32'h0 : prescale + 32'h1;
  end

  kamus_csr_counter #(.W(CNT_W)) u_mcycle (
    .clk(clk_i), .rst(rst_i), .inc(1'b1),
    .wr_lo(we_mcycle), .wr_hi(we_mcycleh), .wdata(new_val), .value(mcycle)
  );

  kamus_csr_counter #(.W(CNT_W)) u_minstret (
    .clk(clk_i), .rst(rst_i), .inc(instr_ret_i),
    .wr_lo(we_minstret), .wr_hi(we_minstreth), .wdata(new_val), .value(minstret)
  );

  kamus_csr_counter #(.W(CNT_W)) u_mtime (
    .clk(clk_i), .rst(rst_i), .inc(time_tick),
    .wr_lo(we_mtime), .wr_hi(we_mtimeh), .wdata(new_val), .value(mtime)
  );

`ifdef KAMUS_CSR_TIMER_EN
  // Comparator register resets to all-ones so nothing fires until set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtimecmp <= '1;
    end else if (we_mtimecmp) begin
      mtimecmp[31:0] <= new_val;
    end else if (we_mtimecmph) begin
      mtimecmp[CNT_W-1:32] <= new_val[CNT_W-33:0];
    end
  end

  // Registered so the core sees a clean level; lags MTIP by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) timer_irq_o <= 1'b0;
    else       timer_irq_o <= mtip & mie_mtie & mstatus_mie;
  end
`else
  assign timer_irq_o = 1'b0;
`endif

endmodule
